// File: rtl/horizon_pkg.sv
// Playfield geometry shared by the horizon obstacle pipeline.
package horizon_pkg;
    localparam int MAX_OBSTACLES = 7;
    localparam int GAME_WIDTH    = 640;
endpackage

// File: rtl/obstacle_pkg.sv
// Obstacle sprite types shared between horizon and the sprite blitter.
package obstacle_pkg;
    typedef logic [2:0] frame_t;
endpackage

// File: rtl/obstacle_scan_pkg.sv
// Types for the per-scanline obstacle reader: FSM states, shadow slot and draw request.
package obstacle_scan_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic                 start;
        logic signed [10:0]   x;
        logic [9:0]           y;
        logic [9:0]           w;
        logic [9:0]           h;
        obstacle_pkg::frame_t frame;
    } slot_t;

    typedef struct packed {
        logic [2:0]           slot;
        logic signed [10:0]   x_begin;
        logic signed [10:0]   x_end;
        logic [9:0]           row;
        obstacle_pkg::frame_t frame;
    } draw_req_t;
endpackage

// File: rtl/obstacle_slot_hit.sv
// Combinational line/slot intersection test and horizontal clip for one shadow slot.
// Horizontal test and clipping are built only when OBSTACLE_SCAN_CLIP_EN is defined.
module obstacle_slot_hit
    import obstacle_scan_pkg::*;
#(
    parameter int GAME_WIDTH = horizon_pkg::GAME_WIDTH
) (
    input  slot_t              slot_i,
    input  logic [9:0]         line_y_i,
    output logic               hit_o,
    output logic signed [10:0] x_begin_o,
    output logic signed [10:0] x_end_o,
    output logic [9:0]         row_o
);
    // Clipped coordinates are carried in signed 11 bits, so the line width must fit there.
    if (GAME_WIDTH < 1 || GAME_WIDTH > 1023) begin : g_bad_width
        $error("obstacle_slot_hit: GAME_WIDTH out of range");
    end

    logic [10:0] y_end;
    logic        v_hit;

    assign y_end = {1'b0, slot_i.y} + {1'b0, slot_i.h};
    assign v_hit = slot_i.start && (slot_i.w != 10'd0) && (slot_i.h != 10'd0) &&
                   (line_y_i >= slot_i.y) && ({1'b0, line_y_i} < y_end);
    assign row_o = line_y_i - slot_i.y;

`ifdef OBSTACLE_SCAN_CLIP_EN
    localparam logic signed [11:0] GW = 12'(GAME_WIDTH);
    logic signed [11:0] x_w;
    logic signed [11:0] x_ext;

    assign x_ext     = {slot_i.x[10], slot_i.x};
    assign x_w       = x_ext + $signed({2'b00, slot_i.w});
    assign hit_o     = v_hit && (x_w > 12'sd0) && (x_ext < GW);
    assign x_begin_o = slot_i.x[10] ? 11'sd0 : slot_i.x;
    assign x_end_o   = (x_w > GW) ? GW[10:0] : x_w[10:0];
`else
    assign hit_o     = v_hit;
    assign x_begin_o = slot_i.x;
    assign x_end_o   = slot_i.x + $signed({1'b0, slot_i.w});
`endif
endmodule

// File: rtl/obstacle_line_scanner.sv
// Per-scanline obstacle reader: snapshots slots on line_start and emits one draw request per hit.
// Optional horizontal clipping via OBSTACLE_SCAN_CLIP_EN (in obstacle_slot_hit).
module obstacle_line_scanner
    import obstacle_scan_pkg::*;
#(
    parameter int MAX_OBSTACLES = horizon_pkg::MAX_OBSTACLES,
    parameter int GAME_WIDTH    = horizon_pkg::GAME_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 line_start,
    input  logic [9:0]           line_y,
    input  logic                 obj_start  [MAX_OBSTACLES],
    input  logic signed [10:0]   obj_x_pos  [MAX_OBSTACLES],
    input  logic [9:0]           obj_y_pos  [MAX_OBSTACLES],
    input  logic [9:0]           obj_width  [MAX_OBSTACLES],
    input  logic [9:0]           obj_height [MAX_OBSTACLES],
    input  obstacle_pkg::frame_t obj_frame  [MAX_OBSTACLES],
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic [2:0]           req_slot,
    output logic signed [10:0]   req_x_begin,
    output logic signed [10:0]   req_x_end,
    output logic [9:0]           req_row,
    output obstacle_pkg::frame_t req_frame,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output state_t               state_dbg
);
    // Handshake: req_valid rises only with all req_* fields registered; both stay
    // unchanged until a cycle with req_valid && req_ready, after which valid drops.
    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    draw_req_t          req_q, req_d;
    logic [9:0]         line_y_q;
    slot_t              shadow_q [MAX_OBSTACLES];
    logic               capture;
    logic               last;
    logic               hit;
    logic signed [10:0] hit_xb, hit_xe;
    logic [9:0]         hit_row;

    obstacle_slot_hit #(.GAME_WIDTH(GAME_WIDTH)) u_hit (
        .slot_i    (shadow_q[idx_q]),
        .line_y_i  (line_y_q),
        .hit_o     (hit),
        .x_begin_o (hit_xb),
        .x_end_o   (hit_xe),
        .row_o     (hit_row)
    );

    assign last = (idx_q == 3'(MAX_OBSTACLES - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        req_d   = req_q;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (line_start) begin
                    capture = 1'b1;
                    idx_d   = 3'd0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (hit) begin
                    req_d.slot    = idx_q;
                    req_d.x_begin = hit_xb;
                    req_d.x_end   = hit_xe;
                    req_d.row     = hit_row;
                    req_d.frame   = shadow_q[idx_q].frame;
                    state_d       = ST_EMIT;
                end else if (last) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_EMIT: begin
                if (req_ready) begin
                    if (last) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= 3'd0;
            req_q    <= '0;
            line_y_q <= 10'd0;
            for (int i = 0; i < MAX_OBSTACLES; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            req_q   <= req_d;
            // Snapshot so slot updates from horizon mid-line cannot tear the scan.
            if (capture) begin
                line_y_q <= line_y;
                for (int i = 0; i < MAX_OBSTACLES; i++) begin
                    shadow_q[i].start <= obj_start[i];
                    shadow_q[i].x     <= obj_x_pos[i];
                    shadow_q[i].y     <= obj_y_pos[i];
                    shadow_q[i].w     <= obj_width[i];
                    shadow_q[i].h     <= obj_height[i];
                    shadow_q[i].frame <= obj_frame[i];
                end
            end
        end
    end

    assign req_valid   = (state_q == ST_EMIT);
    assign req_slot    = req_q.slot;
    assign req_x_begin = req_q.x_begin;
    assign req_x_end   = req_q.x_end;
    assign req_row     = req_q.row;
    assign req_frame   = req_q.frame;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign overrun     = line_start && busy;
    assign state_dbg   = state_q;
endmodule

// File: tb/tb_obstacle_line_scanner.sv
// Directed bench for obstacle_line_scanner: vector table of single-slot scans plus
// hand sequences for backpressure, snapshot, overrun and reset.
module tb_obstacle_line_scanner;
    import obstacle_scan_pkg::*;

    localparam int N = 7;
`ifdef OBSTACLE_SCAN_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 line_start;
    logic [9:0]           line_y;
    logic                 obj_start  [N];
    logic signed [10:0]   obj_x_pos  [N];
    logic [9:0]           obj_y_pos  [N];
    logic [9:0]           obj_width  [N];
    logic [9:0]           obj_height [N];
    obstacle_pkg::frame_t obj_frame  [N];
    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           req_slot;
    logic signed [10:0]   req_x_begin;
    logic signed [10:0]   req_x_end;
    logic [9:0]           req_row;
    obstacle_pkg::frame_t req_frame;
    logic                 busy;
    logic                 done;
    logic                 overrun;
    state_t               state_dbg;

    obstacle_line_scanner dut (
        .clk        (clk),
        .rst        (rst),
        .line_start (line_start),
        .line_y     (line_y),
        .obj_start  (obj_start),
        .obj_x_pos  (obj_x_pos),
        .obj_y_pos  (obj_y_pos),
        .obj_width  (obj_width),
        .obj_height (obj_height),
        .obj_frame  (obj_frame),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_slot   (req_slot),
        .req_x_begin(req_x_begin),
        .req_x_end  (req_x_end),
        .req_row    (req_row),
        .req_frame  (req_frame),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .state_dbg  (state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int total = 0;
    int bad   = 0;
    logic [37:0] exp_q[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [37:0] pack_req(input int s, input int xb, input int xe,
                                             input int row);
        logic [2:0] sl;
        sl = 3'(s);
        return {sl, 11'(xb), 11'(xe), 10'(row), 3'(s + 1)};
    endfunction

    function automatic logic [37:0] dut_req();
        return {req_slot, req_x_begin, req_x_end, req_row, req_frame};
    endfunction

    // drivers
    task automatic clear_slots();
        for (int i = 0; i < N; i++) begin
            obj_start[i]  = 1'b0;
            obj_x_pos[i]  = 11'sd0;
            obj_y_pos[i]  = 10'd0;
            obj_width[i]  = 10'd0;
            obj_height[i] = 10'd0;
            obj_frame[i]  = 3'(i + 1);
        end
    endtask

    task automatic set_slot(input int s, input int act, input int x, input int y,
                            input int w, input int h);
        obj_start[s]  = (act != 0);
        obj_x_pos[s]  = 11'(x);
        obj_y_pos[s]  = 10'(y);
        obj_width[s]  = 10'(w);
        obj_height[s] = 10'(h);
    endtask

    // Pulse line_start and monitor until done; ready held low for the first
    // `stall` valid cycles; at cycle mut_k the x of slot 5 is rewritten.
    task automatic run_scan(input int stall, input int mut_k, output int done_k);
        int          k;
        int          stall_left;
        bit          busy_ok;
        bit          held_v;
        logic [37:0] held;
        logic [37:0] cur;
        done_k     = -1;
        busy_ok    = 1'b1;
        held_v     = 1'b0;
        held       = '0;
        stall_left = stall;
        @(posedge clk); #1 line_start = 1'b1;
        @(posedge clk); #1 line_start = 1'b0;
        k = 1;
        while (k <= 200) begin
            if (k == mut_k) obj_x_pos[5] = 11'sd300;
            req_ready = (stall_left == 0);
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (req_valid) begin
                cur = dut_req();
                if (held_v) check("req_stable", cur, held);
                else begin
                    held   = cur;
                    held_v = 1'b1;
                end
                if (req_ready) begin
                    if (exp_q.size() == 0) check("req_unexpected", cur, '0);
                    else check("req_fields", cur, exp_q.pop_front());
                    held_v = 1'b0;
                end else if (stall_left > 0) begin
                    stall_left--;
                end
            end
            if (done) begin
                done_k = k;
                break;
            end
            @(posedge clk); #1;
            k++;
        end
        req_ready = 1'b1;
        check("req_missing", exp_q.size(), 0);
        check("busy_during_scan", busy_ok, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("busy_after_done", busy, 0);
        exp_q.delete();
    endtask

    typedef struct {
        int slot; int ly; int x; int y; int w; int h; int act; int row;
        int hc; int xbc; int xec; int hn; int xbn; int xen;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int dk;
        int n_done;
        int k;
        bit seen;

        //  slot ly    x    y   w   h  act row | clip hit xb xe | noclip hit xb xe
        vecs[0]  = '{3,  60, 100,  50, 20, 30, 1, 10, 1, 100, 120, 1, 100, 120};
        vecs[1]  = '{0,   5, -10,   0, 25, 10, 1,  5, 1,   0,  15, 1, -10,  15};
        vecs[2]  = '{1,   0, 630,   0, 20, 10, 1,  0, 1, 630, 640, 1, 630, 650};
        vecs[3]  = '{2,   9, -30,   0, 30, 10, 1,  9, 0,   0,   0, 1, -30,   0};
        vecs[4]  = '{4, 110,  50, 100, 10, 10, 1,  0, 0,   0,   0, 0,   0,   0};
        vecs[5]  = '{5,  99,   0, 100,  5, 10, 1,  0, 0,   0,   0, 0,   0,   0};
        vecs[6]  = '{5, 100,   0, 100,  5, 10, 1,  0, 1,   0,   5, 1,   0,   5};
        vecs[7]  = '{6,  20,  10,   0, 10, 30, 0,  0, 0,   0,   0, 0,   0,   0};
        vecs[8]  = '{6,   0,  10,   0,  0, 10, 1,  0, 0,   0,   0, 0,   0,   0};
        vecs[9]  = '{2,   0,  10,   0, 10,  0, 1,  0, 0,   0,   0, 0,   0,   0};
        vecs[10] = '{6,1020,   0,1000,  8,100, 1, 20, 1,   0,   8, 1,   0,   8};
        vecs[11] = '{0,   0, 640,   0, 10,  5, 1,  0, 0,   0,   0, 1, 640, 650};
        vecs[12] = '{4,   3, -20,   0, 21,  5, 1,  3, 1,   0,   1, 1, -20,   1};

        rst        = 1'b1;
        line_start = 1'b0;
        line_y     = 10'd0;
        req_ready  = 1'b1;
        clear_slots();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", req_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_fields", dut_req(), 0);
        check("rst_state", state_dbg, ST_IDLE);
        @(posedge clk); #1 rst = 1'b0;

        // empty line
        run_scan(0, 0, dk);
        check("empty_done_cycle", dk, 8);

        // table-driven single-slot scans
        for (int i = 0; i < 13; i++) begin
            int hit;
            clear_slots();
            set_slot(vecs[i].slot, vecs[i].act, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h);
            line_y = 10'(vecs[i].ly);
            hit = CLIP ? vecs[i].hc : vecs[i].hn;
            if (hit != 0) begin
                if (CLIP) exp_q.push_back(pack_req(vecs[i].slot, vecs[i].xbc, vecs[i].xec, vecs[i].row));
                else      exp_q.push_back(pack_req(vecs[i].slot, vecs[i].xbn, vecs[i].xen, vecs[i].row));
            end
            run_scan(0, 0, dk);
            check($sformatf("vec%0d_done_cycle", i), dk, 8 + hit);
        end

        // backpressure, ordering and snapshot isolation
        clear_slots();
        set_slot(1, 1, 10, 0, 10, 5);
        set_slot(5, 1, 200, 0, 50, 5);
        line_y = 10'd2;
        exp_q.push_back(pack_req(1, 10, 20, 2));
        exp_q.push_back(pack_req(5, 200, 250, 2));
        run_scan(4, 3, dk);
        check("stall_done_cycle", dk, 14);

        // overrun mid-scan and in the DONE cycle
        clear_slots();
        line_y = 10'd0;
        @(posedge clk); #1 line_start = 1'b1;
        @(posedge clk); #1 line_start = 1'b0;
        n_done = 0;
        dk     = -1;
        for (int c = 1; c <= 14; c++) begin
            line_start = (c == 3 || c == 8);
            @(negedge clk);
            if (c == 3)  check("overrun_mid", overrun, 1);
            if (c == 4)  check("overrun_clear", overrun, 0);
            if (c == 8)  check("overrun_done_cycle", overrun, 1);
            if (c == 12) check("no_restart_after_overrun", busy, 0);
            if (done) begin
                n_done++;
                if (dk < 0) dk = c;
            end
            @(posedge clk); #1;
        end
        line_start = 1'b0;
        check("overrun_done_at", dk, 8);
        check("overrun_done_count", n_done, 1);

        // reset while a request is stalled
        clear_slots();
        set_slot(2, 1, 5, 0, 5, 5);
        line_y    = 10'd0;
        @(posedge clk); #1 line_start = 1'b1;
        @(posedge clk); #1 line_start = 1'b0;
        req_ready = 1'b0;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            seen = req_valid;
            k++;
        end
        check("emit_reached", seen, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_req_valid", req_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_fields", dut_req(), 0);
        @(posedge clk); #1 rst = 1'b0;
        req_ready = 1'b1;
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("rst_mid_no_done", n_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/obstacle_line_scanner.md
# obstacle_line_scanner

Per-scanline reader for the horizon obstacle slot array. On each line-start pulse it snapshots the active obstacle slots and walks them in index order. For every slot that intersects the current line it emits one clipped draw request to the sprite line-buffer filler over a valid/ready handshake. It sits between `horizon` and the obstacle sprite blitter.

## Interface
Parameters:
- `MAX_OBSTACLES`, 7: number of slots scanned; matches `horizon_pkg::MAX_OBSTACLES`.
- `GAME_WIDTH`, 640: visible line width in pixels.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `line_start` in 1: one-cycle pulse that starts a scan of `line_y`.
- `line_y` in 10: current line; sampled with `line_start`.
- `obj_start[MAX_OBSTACLES]` in 1 each: slot active.
- `obj_x_pos[MAX_OBSTACLES]` in signed 11 each: left edge.
- `obj_y_pos[MAX_OBSTACLES]` in 10 each: top edge.
- `obj_width[MAX_OBSTACLES]` in 10 each: width in pixels.
- `obj_height[MAX_OBSTACLES]` in 10 each: height in pixels.
- `obj_frame[MAX_OBSTACLES]` in `obstacle_pkg::frame_t` each: sprite frame.
- `req_valid` out 1: draw request valid.
- `req_ready` in 1: blitter accepts the request.
- `req_slot` out 3: slot index.
- `req_x_begin` out signed 11: first pixel, inclusive.
- `req_x_end` out signed 11: last pixel, exclusive.
- `req_row` out 10: row within the sprite (`line_y - y_pos`).
- `req_frame` out `obstacle_pkg::frame_t`: frame of the slot.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse when the line scan completes.
- `overrun` out 1: one-cycle pulse when `line_start` arrives while `busy`.

## Operation
States are IDLE, SCAN, EMIT and DONE.

- **IDLE**
  - On `line_start`: latch `line_y` and all slot inputs into shadow registers, set slot index to 0, go to SCAN.
  - Later changes to the slot inputs do not affect the scan in progress.
- **SCAN**: evaluate the shadow slot at the current index.
  - Hit condition: `start` && `line_y >= y` && `line_y < y + height` && `x + width > 0` && `x < GAME_WIDTH`.
  - On a hit: register the request fields, assert `req_valid`, go to EMIT.
  - On a miss: increment the index. After slot `MAX_OBSTACLES-1`, go to DONE.
- **EMIT**
  - Hold `req_valid` and every `req_*` field stable until `req_valid && req_ready`.
  - On transfer: deassert `req_valid`, then increment the index and return to SCAN, or go to DONE after the last slot.
- **DONE**: pulse `done` for one cycle, then go to IDLE.

Arithmetic and width rules:
- Compute `y + height` in 11 bits unsigned; no wrap.
- Compute `x + width` in 12 bits signed.
- Clipped output: `req_x_begin = max(x, 0)` and `req_x_end = min(x + width, GAME_WIDTH)`.
- A slot with `width == 0` or `height == 0` never hits.

Boundary conditions:
- `line_start` while busy: ignored, `overrun` pulses, the current scan is unaffected.
- `line_start` in the DONE cycle: also counts as busy and is ignored.
- `req_ready` high while `req_valid` is low: no effect.
- `rst` mid-scan: all state returns to reset values on the next edge; `req_valid` drops and no `done` is produced.

## Timing
- Reset values: `req_valid`, `busy`, `done` and `overrun` are 0; all `req_*` fields are 0; state is IDLE.
- Cycle counts for `line_start` sampled at edge T, slot evaluations at T+1 … T+`MAX_OBSTACLES`:
  - No hits: `done` is high in cycle T+`MAX_OBSTACLES`+1.
  - Each hit accepted in its first valid cycle adds 1 cycle.
  - Each cycle `req_ready` is held low adds 1 cycle.
- `req_valid` first rises the cycle after the SCAN cycle of the hitting slot.
- `busy` is high from T+1 through the DONE cycle inclusive.
- Requests are strictly in ascending slot order.

## Configuration
Macro: `OBSTACLE_SCAN_CLIP_EN`.
- **Defined**:
  - Horizontal clipping as described above.
  - Slots with `x + width <= 0` or `x >= GAME_WIDTH` are misses.
- **Undefined**:
  - No clipping and no horizontal test; only the activity and vertical tests apply.
  - `req_x_begin = x` and `req_x_end` = low 11 bits of `x + width`; the blitter clips.

## Structure
- `obstacle_scan_pkg`: `state_t` (IDLE/SCAN/EMIT/DONE) and the `draw_req_t` struct of the `req_*` fields. `GAME_WIDTH` comes from `horizon_pkg`.
- Sub-module `obstacle_slot_hit`: combinational hit test and clip for one shadow slot. It is instantiated once on the indexed slot and contains the `OBSTACLE_SCAN_CLIP_EN` logic.

## Test plan
- **Empty line**: all `obj_start` 0, `line_start` at T → no `req_valid`; `done` at T+8; `busy` high T+1..T+8.
- **Single hit, ready tied high**: slot 3 at x=100, y=50, w=20, h=30, `line_y`=60 → one request with slot=3, x_begin=100, x_end=120, row=10; `done` at T+9.
- **Clipping, macro defined**: slot 0 at x=-10, w=25 → x_begin=0, x_end=15. Slot 1 at x=630, w=20 → x_begin=630, x_end=640. Slot 2 at x=-30, w=30 → no request.
- **Backpressure and snapshot**: two hits (slots 1 and 5), `req_ready` low for 4 cycles on the first request → fields stable while stalled; slot order 1 then 5. Changing `obj_x_pos[5]` mid-scan does not alter its request.
- **Overrun and reset**: `line_start` pulsed during a scan → `overrun` for 1 cycle, `done` count unchanged. `rst` asserted while in EMIT → next cycle `req_valid`=0, `busy`=0, and no `done`.
